// File: rtl/dff_mem_arbiter_if.sv
// Bundle of every non-clock signal between the two requesters, the arbiter
// and the single-port DFF RAM.
//   req*_valid/we/addr/wdata : requester -> arbiter request fields
//   req*_ready               : arbiter -> requester, request accepted this cycle
//   rsp*_valid/rdata         : arbiter -> requester, read response
//   clear_start/clear_busy   : zero-fill control / status
//   mem_addr/we/wdata        : arbiter -> RAM pins
//   mem_rdata                : RAM -> arbiter, registered read data
// The slave modport is the arbiter's view. The master modport is the
// environment's view: the requesters plus the RAM.
interface dff_mem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              req0_valid, req0_ready, req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid, req1_ready, req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic              clear_start, clear_busy;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  clear_start, mem_rdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output clear_busy, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output clear_start, mem_rdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  clear_busy, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/dff_mem_arbiter.sv
// Round-robin arbiter sharing one single-port DFF RAM between two
// valid/ready requesters. It also contains a sequencer that zero-fills
// the whole RAM.
//   clk   : clock
//   rst_n : synchronous, active-low reset
//   bus   : dff_mem_arbiter_if.slave, which carries the requester ports,
//           the clear control and the RAM pins
module dff_mem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    dff_mem_arbiter_if.slave   bus
);
    typedef enum logic {ST_ARB, ST_CLEAR} state_e;

    state_e            state_q, state_d;
    logic              rr_last_q, rr_last_d;   // port granted most recently
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;         // mem_addr holds this when idle
    logic [1:0]        rd_pend_q, rd_pend_d;   // read accepted last cycle, per port
    logic [DATA_W-1:0] hold0_q, hold1_q;
    logic              gnt0, gnt1;

    always_comb begin
        state_d       = state_q;
        rr_last_d     = rr_last_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        rd_pend_d     = '0;
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        bus.mem_addr  = addr_q;
        case (state_q)
            ST_ARB: begin
                // clear_start wins over any request in the same cycle
                if (bus.clear_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else begin
                    // When both ports are valid, the port not served last wins.
                    gnt0 = bus.req0_valid & (~bus.req1_valid | rr_last_q);
                    gnt1 = bus.req1_valid & (~bus.req0_valid | ~rr_last_q);
                    if (gnt0) begin
                        bus.mem_addr  = bus.req0_addr;
                        bus.mem_we    = bus.req0_we;
                        bus.mem_wdata = bus.req0_wdata;
                        addr_d        = bus.req0_addr;
                        rr_last_d     = 1'b0;
                        rd_pend_d[0]  = ~bus.req0_we;
                    end else if (gnt1) begin
                        bus.mem_addr  = bus.req1_addr;
                        bus.mem_we    = bus.req1_we;
                        bus.mem_wdata = bus.req1_wdata;
                        addr_d        = bus.req1_addr;
                        rr_last_d     = 1'b1;
                        rd_pend_d[1]  = ~bus.req1_we;
                    end
                end
            end
            ST_CLEAR: begin
                bus.mem_we   = 1'b1;
                bus.mem_addr = cnt_q;
                addr_d       = cnt_q;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = ST_ARB;
            end
            default: state_d = ST_ARB;
        endcase
        // Reset is synchronous, so the RAM pins are gated combinationally.
        // Otherwise the RAM would be written during the reset cycle.
        if (!rst_n) begin
            gnt0       = 1'b0;
            gnt1       = 1'b0;
            bus.mem_we = 1'b0;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.clear_busy = (state_q == ST_CLEAR);
    // A reset in the response cycle suppresses the response.
    assign bus.rsp0_valid = rd_pend_q[0] & rst_n;
    assign bus.rsp1_valid = rd_pend_q[1] & rst_n;
    assign bus.rsp0_rdata = rd_pend_q[0] ? bus.mem_rdata : hold0_q;
    assign bus.rsp1_rdata = rd_pend_q[1] ? bus.mem_rdata : hold1_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_ARB;
            rr_last_q <= 1'b1;
            cnt_q     <= '0;
            addr_q    <= '0;
            rd_pend_q <= '0;
            hold0_q   <= '0;
            hold1_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            rd_pend_q <= rd_pend_d;
            if (rd_pend_q[0]) hold0_q <= bus.mem_rdata;
            if (rd_pend_q[1]) hold1_q <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_dff_mem_arbiter.sv
// Directed bench for dff_mem_arbiter with a behavioural read-before-write RAM.
module tb_dff_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    dff_mem_arbiter_if #(.ADDR_W(5), .DATA_W(8)) bus ();
    dff_mem_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic [7:0] ram [32];
    always @(posedge clk) begin
        bus.mem_rdata <= ram[bus.mem_addr];
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic we,
                           input logic [4:0] a, input logic [7:0] d);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction
    function automatic logic rspv(input int p);
        return (p == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    endfunction
    function automatic logic [7:0] rspd(input int p);
        return (p == 0) ? bus.rsp0_rdata : bus.rsp1_rdata;
    endfunction

    task automatic wait_ready(input int p);
        int n = 0;
        #1;
        while (!rdy(p) && n < 50) begin tick(); n++; end
        if (n >= 50) chk($sformatf("ready_timeout_p%0d", p), 0, 1);
    endtask

    task automatic do_write(input int p, input logic [4:0] a, input logic [7:0] d);
        set_req(p, 1'b1, 1'b1, a, d);
        wait_ready(p);
        tick();
        set_req(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_read(input int p, input logic [4:0] a, input logic [7:0] exp, input string tag);
        set_req(p, 1'b1, 1'b0, a, '0);
        wait_ready(p);
        tick();
        set_req(p, 1'b0, 1'b0, '0, '0);
        #1;
        chk({tag, "_v"}, rspv(p), 1);
        chk({tag, "_d"}, rspd(p), exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        bus.clear_start = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int n, bad;
        for (int i = 0; i < 32; i++) ram[i] = 8'h00;
        rst_n = 1'b0;
        bus.clear_start = 1'b0;
        set_req(1, 1'b0, 1'b0, '0, '0);
        // A write request held during reset must not reach the RAM.
        set_req(0, 1'b1, 1'b1, 5'd1, 8'h77);
        tick(); tick(); #1;
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_busy", bus.clear_busy, 0);
        chk("rst_rspv", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        do_reset();

        // Port0 writes, port1 reads the same word back.
        do_write(0, 5'd3, 8'hA5);
        do_read(1, 5'd3, 8'hA5, "t1_rd");
        chk("t1_rsp0_quiet", bus.rsp0_valid, 0);
        tick();
        chk("t1_rsp1_one_cycle", bus.rsp1_valid, 0);
        chk("t1_rsp1_hold", bus.rsp1_rdata, 8'hA5);

        // Both ports hold reads, so grants alternate starting with port0.
        do_reset();
        set_req(0, 1'b1, 1'b0, 5'd3, '0);
        set_req(1, 1'b1, 1'b0, 5'd3, '0);
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_gnt%0d", i), {bus.req1_ready, bus.req0_ready},
                (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0)
                chk($sformatf("t2_rsp%0d", i), {bus.rsp1_valid, bus.rsp0_valid},
                    (i % 2 == 0) ? 2'b10 : 2'b01);
            tick();
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);

        // A reset in the response cycle suppresses the response.
        set_req(0, 1'b1, 1'b0, 5'd3, '0);
        wait_ready(0);
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        #1;
        chk("rst_supp_rsp0", bus.rsp0_valid, 0);
        tick();
        rst_n = 1'b1;

        // Full clear, with a port1 read held pending across it.
        for (int a = 0; a < 32; a++) do_write(a % 2, a[4:0], 8'hFF);
        bus.clear_start = 1'b1;
        set_req(1, 1'b1, 1'b0, 5'd5, '0);
        #1;
        chk("t3_start_prio", bus.req1_ready, 0);
        tick();
        bus.clear_start = 1'b0;
        n = 0; bad = 0;
        #1;
        while (bus.clear_busy && n < 100) begin
            if (bus.mem_addr != n[4:0] || !bus.mem_we || bus.mem_wdata != 8'h00 ||
                bus.req0_ready || bus.req1_ready)
                bad++;
            n++;
            tick(); #1;
        end
        chk("t3_busy_cycles", n, 32);
        chk("t3_clear_cycle_bad", bad, 0);
        chk("t4_ready_after_clear", bus.req1_ready, 1);
        tick();
        set_req(1, 1'b0, 1'b0, '0, '0);
        #1;
        chk("t4_rsp_v", bus.rsp1_valid, 1);
        chk("t4_rsp_d", bus.rsp1_rdata, 8'h00);
        for (int a = 0; a < 32; a++) do_read(0, a[4:0], 8'h00, $sformatf("t3_rd%0d", a));

        // Reset while the clear counter is at 10.
        for (int a = 0; a < 32; a++) do_write(0, a[4:0], 8'hFF);
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        repeat (10) tick();
        chk("t5_cnt10", bus.mem_addr, 10);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_we", bus.mem_we, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("t5_busy_off", bus.clear_busy, 0);
        for (int a = 0; a < 32; a++)
            do_read(1, a[4:0], (a < 10) ? 8'h00 : 8'hFF, $sformatf("t5_rd%0d", a));

        // Simultaneous write and read of the same word.
        do_reset();
        do_write(1, 5'd7, 8'h11);
        set_req(0, 1'b1, 1'b1, 5'd7, 8'h3C);
        set_req(1, 1'b1, 1'b0, 5'd7, '0);
        #1;
        chk("t6_gnt_first", {bus.req1_ready, bus.req0_ready}, 2'b01);
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("t6_gnt_second", {bus.req1_ready, bus.req0_ready}, 2'b10);
        tick();
        set_req(1, 1'b0, 1'b0, '0, '0);
        #1;
        chk("t6_rsp_v", bus.rsp1_valid, 1);
        chk("t6_rsp_d", bus.rsp1_rdata, 8'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
